// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-free shifter (SLL/SRL/SRA/ROR), one bit per clock,
// with a valid/ready request port and a valid/ready result port.
module seq_shifter #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data
);
    localparam int W = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state, state_nx;
    logic [N-1:0] work, work_nx, step;
    logic [W-1:0] cnt, cnt_nx;
    logic [1:0]   op, op_nx;

    // One-bit step for the latched op: 00 SLL, 01 SRL, 10 SRA, 11 ROR
    always_comb
        step = op == 2'b00 ? {work[N-2:0], 1'b0} :
               op == 2'b01 ? {1'b0, work[N-1:1]} :
               op == 2'b10 ? {work[N-1], work[N-1:1]} :
                             {work[0], work[N-1:1]};

    always_comb begin
        state_nx = state;
        work_nx  = work;
        cnt_nx   = cnt;
        op_nx    = op;
        case (state)
            IDLE:
                if (in_valid) begin
                    state_nx = SHIFT;
                    work_nx  = in_data;
                    cnt_nx   = in_shamt;
                    op_nx    = in_op;
                end
            SHIFT:
                if (cnt == '0)
                    state_nx = DONE;
                else begin
                    work_nx = step;
                    cnt_nx  = cnt - 1'b1;
                end
            DONE:
                if (out_ready)
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            op    <= '0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            cnt   <= cnt_nx;
            op    <= op_nx;
        end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = work;
endmodule
